// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths and reset constants for sync_fifo_param
package fifo_pkg;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam logic RST_EMPTY = 1'b1;
  localparam logic RST_FULL = 1'b0;
  localparam logic RST_AE = 1'b1;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DATA_W x DEPTH dual-port array, one write port, one registered read port
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  assign rd_data_d = re ? mem[raddr] : rd_data_q;
  assign rd_data = rd_data_q;
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // read register resets so data_out starts at zero; the array itself does not
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count, thresholds, error pulses; FIFO_HWM_EN adds hwm/hwm_clr
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   w_en,
  input  logic                   r_en,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
`ifdef FIFO_HWM_EN
  ,
  input  logic                   hwm_clr,
  output logic [$clog2(DEPTH):0] hwm
`endif
);
  localparam int AW = addr_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, unf_q, unf_d, wr_ok, rd_ok;
  always_comb begin
    rd_ok = r_en && !empty_q;
    wr_ok = w_en && (!full_q || rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + PW'(wr_ok) - PW'(rd_ok);
    full_d = count_d == PW'(DEPTH);
    empty_d = count_d == '0;
    af_d = count_d >= PW'(AF_LEVEL);
    ae_d = count_d <= PW'(AE_LEVEL);
    ovf_d = w_en && !wr_ok;
    unf_d = r_en && !rd_ok;
  end
  fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .rst_n(rst_n), .we(wr_ok), .waddr(wr_ptr_q[AW-1:0]), .wdata(data_in),
    .re(rd_ok), .raddr(rd_ptr_q[AW-1:0]), .rd_data(data_out)
  );
  // flags are registered from count_d so they line up with count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      full_q <= RST_FULL;
      empty_q <= RST_EMPTY;
      af_q <= (AF_LEVEL == 0);
      ae_q <= RST_AE;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
      af_q <= af_d;
      ae_q <= ae_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign count = count_q;
  assign full = full_q;
  assign empty = empty_q;
  assign almost_full = af_q;
  assign almost_empty = ae_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
`ifdef FIFO_HWM_EN
  logic [PW-1:0] hwm_q, hwm_d;
  assign hwm_d = hwm_clr ? count_d : (count_d > hwm_q ? count_d : hwm_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hwm_q <= '0;
    else hwm_q <= hwm_d;
  assign hwm = hwm_q;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table-driven check of sync_fifo_param (DEPTH=8, AF=6, AE=2); FIFO_HWM_EN checks hwm
module tb_sync_fifo_param;
  logic clk = 1'b0, rst_n = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int n_vec = 0, n_err = 0;
`ifdef FIFO_HWM_EN
  logic hwm_clr = 1'b0;
  logic [3:0] hwm;
`endif
  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .w_en(w_en), .r_en(r_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
`ifdef FIFO_HWM_EN
    , .hwm_clr(hwm_clr), .hwm(hwm)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {
    logic w, r;
    logic [7:0] din;
    logic [3:0] cnt;
    logic [7:0] dout;
    logic ovf, unf;
  } vec_t;
  vec_t tbl[$];
  logic [7:0] q_model[$];

  function automatic void add(input int w, r, din, cnt, dout, ovf, unf);
    vec_t v;
    v.w = 1'(w); v.r = 1'(r); v.din = 8'(din); v.cnt = 4'(cnt);
    v.dout = 8'(dout); v.ovf = 1'(ovf); v.unf = 1'(unf);
    tbl.push_back(v);
  endfunction

  function automatic logic [17:0] expect_of(input logic [3:0] c, input logic o, u, input logic [7:0] d);
    return {c, c == 4'd8, c == 4'd0, c >= 4'd6, c <= 4'd2, o, u, d};
  endfunction

  task automatic check(input string name, input logic [17:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {cnt,full,empty,af,ae,ovf,unf,dout}=%h want %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] outs();
    return {count, full, empty, almost_full, almost_empty, overflow, underflow, data_out};
  endfunction

  initial begin
    logic [7:0] exp_dout;
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(1, 0, k, k, 0, 0, 0);
    add(1, 0, 8'hFF, 8, 0, 1, 0);
    add(0, 0, 0, 8, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 8 - k, k, 0, 0);
    add(0, 1, 0, 0, 8, 0, 1);
    add(0, 0, 0, 0, 8, 0, 0);
    for (int k = 1; k <= 8; k++) add(1, 0, 8'h10 + k, k, 8, 0, 0);
    add(1, 1, 8'hAA, 8, 8'h11, 0, 0);
    for (int k = 2; k <= 8; k++) add(0, 1, 0, 9 - k, 8'h10 + k, 0, 0);
    add(0, 1, 0, 0, 8'hAA, 0, 0);
    add(1, 1, 8'h55, 1, 8'hAA, 0, 1);
    add(0, 1, 0, 0, 8'h55, 0, 0);

    repeat (2) @(posedge clk);
    #1 check("in_reset", outs(), expect_of(4'd0, 1'b0, 1'b0, 8'h00));
    @(negedge clk) rst_n = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      w_en = tbl[i].w; r_en = tbl[i].r; data_in = tbl[i].din;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), outs(), expect_of(tbl[i].cnt, tbl[i].ovf, tbl[i].unf, tbl[i].dout));
    end

    exp_dout = 8'h55;
    for (int i = 0; i < 20; i++) begin
      logic rd_ok, wr_ok;
      @(negedge clk);
      w_en = 1'b1; r_en = (i >= 3); data_in = 8'(8'h30 + i);
      rd_ok = r_en && q_model.size() > 0;
      wr_ok = w_en && (q_model.size() < 8 || rd_ok);
      if (rd_ok) exp_dout = q_model.pop_front();
      if (wr_ok) q_model.push_back(data_in);
      @(posedge clk);
      #1 check($sformatf("wrap%0d", i), outs(), expect_of(4'(q_model.size()), 1'b0, 1'b0, exp_dout));
    end
`ifdef FIFO_HWM_EN
    check_val("hwm_before_reset", {4'd0, hwm}, 8'd8);
`endif
    @(negedge clk);
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE;
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), expect_of(4'd0, 1'b0, 1'b0, 8'h00));
`ifdef FIFO_HWM_EN
    check_val("hwm_after_reset", {4'd0, hwm}, 8'd0);
`endif
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_reset_idle", outs(), expect_of(4'd0, 1'b0, 1'b0, 8'h00));
`ifdef FIFO_HWM_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      w_en = 1'b1; data_in = 8'(8'h60 + k);
    end
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b1; hwm_clr = 1'b1;
    @(posedge clk);
    #1 check_val("hwm_clr", {4'd0, hwm}, 8'd2);
    check_val("hwm_clr_dout", data_out, 8'h60);
    @(negedge clk);
    r_en = 1'b0; hwm_clr = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
